scr1_accel_dma: RTL and testbench
=================================

SCR1_ACCEL_DMA -- requirements
Module: scr1_accel_dma

Interface
Parameters:
REQ-001 ACCEL_BASE, default 32'h0001_0000, byte base address of the SHA-256 accelerator window.
REQ-002 POLL_MAX, default 16'd1024, maximum status polls before timeout error.

Ports:
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  one-cycle pulse; starts one 64-byte block transfer and hash; ignored while busy.
REQ-006 src_addr  input  32  word-aligned byte address of the 16-word input block; sampled on accepted start.
REQ-007 dst_addr  input  32  word-aligned byte address of the 8-word digest destination; sampled on accepted start.
REQ-008 busy  output  1  high from the cycle after an accepted start until done or error.
REQ-009 done  output  1  one-cycle pulse on successful completion.
REQ-010 error  output  1  sticky; set on bus error or poll timeout; cleared by the next accepted start.
REQ-011 dmem_req  output  1  SCR1 dmem master request.
REQ-012 dmem_cmd  output  type_scr1_mem_cmd_e  RD or WR.
REQ-013 dmem_width  output  type_scr1_mem_width_e  always SCR1_MEM_WIDTH_WORD.
REQ-014 dmem_addr  output  `SCR1_DMEM_AWIDTH  byte address, bits[1:0]=0.
REQ-015 dmem_wdata  output  `SCR1_DMEM_DWIDTH  write data.
REQ-016 dmem_req_ack  input  1  slave accepts the request this cycle.
REQ-017 dmem_rdata  input  `SCR1_DMEM_DWIDTH  read data, valid with RDY_OK.
REQ-018 dmem_resp  input  type_scr1_mem_resp_e  NOTRDY / RDY_OK / RDY_ER.

Function
REQ-019 Accelerator map, offsets from ACCEL_BASE: 0x00 control/status (write = go, bit31 = done), 0x04-0x20 state[0..7], 0x24-0x60 data[0..15].
REQ-020 Transaction rule: dmem_req and all command fields stay stable until the cycle dmem_req_ack=1. dmem_req drops the next cycle. At most one transaction is outstanding.
REQ-021 A transaction completes on the first cycle with dmem_resp != NOTRDY after acceptance. RDY_OK on a read captures dmem_rdata into a 32-bit holding register.
REQ-022 FSM states: IDLE, LD_RD, LD_WR, GO, POLL, ST_RD, ST_WR, FIN, ERR. Each non-IDLE memory state has a REQ phase and a RSP phase.
REQ-023 IDLE -> LD_RD on start. LD_RD reads src_addr+4*i. LD_WR writes the held word to ACCEL_BASE+0x24+4*i. The loop runs for i=0..15, then goes to GO.
REQ-024 GO writes 32'h1 to ACCEL_BASE+0x00, then goes to POLL.
REQ-025 POLL reads ACCEL_BASE+0x00. Bit31=1 -> ST_RD. Bit31=0 -> re-poll and increment poll_cnt.
REQ-026 poll_cnt reaching POLL_MAX -> ERR.
REQ-027 ST_RD reads ACCEL_BASE+0x04+4*j. ST_WR writes the held word to dst_addr+4*j. The loop runs for j=0..7, then goes to FIN.
REQ-028 FIN pulses done for one cycle and returns to IDLE. ERR sets error and returns to IDLE the next cycle.
REQ-029 Any RDY_ER response -> ERR immediately. Remaining words are not transferred.
REQ-030 Address arithmetic is 32-bit modulo 2^32. Wrap past 32'hFFFF_FFFC is allowed and not flagged.
REQ-031 The word index is 4 bits and the digest index is 3 bits. Terminal counts are 15 and 7; no overflow past terminal.
REQ-032 start while busy is ignored. start coinciding with FIN or ERR is ignored; a new start is accepted only in IDLE.
REQ-033 Minimum latency with zero-wait slave (ack same cycle, resp next cycle): 2 cycles per access. Total = 2*(32+1+P+16) cycles from start to done, where P is the number of polls.

Reset
REQ-034 rst asserted at any time (including mid-transaction) forces state IDLE within the same cycle, asynchronously.
REQ-035 Reset values: dmem_req=0, dmem_cmd=RD, dmem_addr=0, dmem_wdata=0, busy=0, done=0, error=0, counters and holding register 0.
REQ-036 A transaction abandoned by reset is not retried.

Structure
REQ-037 Accelerator register offsets, the done-bit index and the FSM state enum belong in shared package scr1_accel_pkg, also used by the accelerator and software headers.
REQ-038 One sub-module, scr1_dmem_master_if, owns the REQ/RSP handshake: it takes cmd/addr/wdata/go and returns rdata/ok/err.

Verification
REQ-039 Zero-wait slave; src words 0x03020100+0x04040404*i; accelerator done after 3 polls -> 16 writes to 0x24..0x60 in order, one go write, 4 status reads, 8 digest words at dst_addr, done pulse at cycle 2*(49+4)=106.
REQ-040 Slave withholds dmem_req_ack 5 cycles on every 3rd request -> addr/cmd/wdata stable while req=1; same data result, latency +5 per stalled access.
REQ-041 RDY_ER on the 7th source read -> error=1, busy=0, no LD_WR for word 6, no go write.
REQ-042 Accelerator never sets bit31, POLL_MAX=8 -> exactly 8 status reads, then error=1.
REQ-043 rst pulsed during ST_WR j=3 -> all outputs at reset values the same cycle; a following start with no rst completes normally.
REQ-044 start pulsed while busy plus src_addr=32'hFFFF_FFE0 -> second start ignored; source addresses wrap to 0x0000_0000..0x0000_001C without error.

Source files
------------

// File: rtl/scr1_accel_pkg.sv
// scr1_accel_pkg: shared SCR1 dmem types, SHA-256 accelerator register map and DMA FSM states
package scr1_accel_pkg;
  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;
  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;
  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;
  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
  localparam logic [31:0] ACCEL_CSR_OFS   = 32'h00;
  localparam logic [31:0] ACCEL_STATE_OFS = 32'h04;
  localparam logic [31:0] ACCEL_DATA_OFS  = 32'h24;
  localparam logic [31:0] ACCEL_GO        = 32'h1;
  localparam int          ACCEL_DONE_BIT  = 31;
  typedef enum logic [3:0] {
    DMA_IDLE, DMA_LD_RD, DMA_LD_WR, DMA_GO, DMA_POLL, DMA_ST_RD, DMA_ST_WR, DMA_FIN, DMA_ERR
  } dma_state_e;
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [3:0] idx);
    return base + {26'd0, idx, 2'b00};
  endfunction
endpackage

// File: rtl/scr1_dmem_master_if.sv
// scr1_dmem_master_if: single-outstanding SCR1 dmem request/response handshake
module scr1_dmem_master_if
  import scr1_accel_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          go,
  input  type_scr1_mem_cmd_e            cmd,
  input  logic [SCR1_DMEM_AWIDTH-1:0]   addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0]   wdata,
  output logic [SCR1_DMEM_DWIDTH-1:0]   rdata,
  output logic                          ok,
  output logic                          err,
  output logic                          dmem_req,
  output type_scr1_mem_cmd_e            dmem_cmd,
  output type_scr1_mem_width_e          dmem_width,
  output logic [SCR1_DMEM_AWIDTH-1:0]   dmem_addr,
  output logic [SCR1_DMEM_DWIDTH-1:0]   dmem_wdata,
  input  logic                          dmem_req_ack,
  input  logic [SCR1_DMEM_DWIDTH-1:0]   dmem_rdata,
  input  type_scr1_mem_resp_e           dmem_resp
);
  logic pend;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      pend       <= 1'b0;
      dmem_cmd   <= SCR1_MEM_CMD_RD;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      dmem_req <= go | (dmem_req & ~dmem_req_ack);
      pend     <= (dmem_req & dmem_req_ack) | (pend & (dmem_resp == SCR1_MEM_RESP_NOTRDY));
      if (go) begin
        dmem_cmd   <= cmd;
        dmem_addr  <= addr;
        dmem_wdata <= wdata;
      end
    end
  end
  assign ok         = pend && dmem_resp == SCR1_MEM_RESP_RDY_OK;
  assign err        = pend && dmem_resp == SCR1_MEM_RESP_RDY_ER;
  assign rdata      = dmem_rdata;
  assign dmem_width = SCR1_MEM_WIDTH_WORD;
endmodule

// File: rtl/scr1_accel_dma.sv
// scr1_accel_dma: moves a 64-byte block into the SHA-256 accelerator, runs it, and copies the digest out
module scr1_accel_dma
  import scr1_accel_pkg::*;
#(
  parameter logic [31:0] ACCEL_BASE = 32'h0001_0000,
  parameter logic [15:0] POLL_MAX   = 16'd1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [31:0]                   src_addr,
  input  logic [31:0]                   dst_addr,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic                          dmem_req,
  output type_scr1_mem_cmd_e            dmem_cmd,
  output type_scr1_mem_width_e          dmem_width,
  output logic [SCR1_DMEM_AWIDTH-1:0]   dmem_addr,
  output logic [SCR1_DMEM_DWIDTH-1:0]   dmem_wdata,
  input  logic                          dmem_req_ack,
  input  logic [SCR1_DMEM_DWIDTH-1:0]   dmem_rdata,
  input  type_scr1_mem_resp_e           dmem_resp
);
  dma_state_e         state, state_n;
  logic [3:0]         idx;
  logic [2:0]         didx;
  logic [15:0]        poll_cnt;
  logic [31:0]        src, dst, hold, addr, wdata, rdata;
  type_scr1_mem_cmd_e cmd;
  logic               go, ok, err, accept, last_ld, last_st, acc_done, timeout;
  assign accept   = start && state == DMA_IDLE;
  assign last_ld  = idx == 4'd15;
  assign last_st  = didx == 3'd7;
  assign acc_done = rdata[ACCEL_DONE_BIT];
  assign timeout  = (poll_cnt + 16'd1) == POLL_MAX;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DMA_IDLE;
      idx      <= '0;
      didx     <= '0;
      poll_cnt <= '0;
      src      <= '0;
      dst      <= '0;
      hold     <= '0;
      error    <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        src      <= src_addr;
        dst      <= dst_addr;
        idx      <= '0;
        didx     <= '0;
        poll_cnt <= '0;
      end
      if (ok && dmem_cmd == SCR1_MEM_CMD_RD) hold <= rdata;
      if (ok && state == DMA_LD_WR && !last_ld) idx <= idx + 4'd1;
      if (ok && state == DMA_ST_WR && !last_st) didx <= didx + 3'd1;
      if (ok && state == DMA_POLL && !acc_done) poll_cnt <= poll_cnt + 16'd1;
      error <= accept ? 1'b0 : (error | (state_n == DMA_ERR));
    end
  end
  always_comb begin
    state_n = state;
    unique case (state)
      DMA_IDLE:  if (start) state_n = DMA_LD_RD;
      DMA_LD_RD: if (ok) state_n = DMA_LD_WR;
      DMA_LD_WR: if (ok) state_n = last_ld ? DMA_GO : DMA_LD_RD;
      DMA_GO:    if (ok) state_n = DMA_POLL;
      DMA_POLL:  if (ok) state_n = acc_done ? DMA_ST_RD : (timeout ? DMA_ERR : DMA_POLL);
      DMA_ST_RD: if (ok) state_n = DMA_ST_WR;
      DMA_ST_WR: if (ok) state_n = last_st ? DMA_FIN : DMA_ST_RD;
      DMA_FIN, DMA_ERR: state_n = DMA_IDLE;
      default:   state_n = DMA_IDLE;
    endcase
    if (err) state_n = DMA_ERR;
  end
  // The next access is issued in the cycle the previous one completes, giving two cycles per access.
  always_comb begin
    busy  = !(state inside {DMA_IDLE, DMA_FIN, DMA_ERR});
    done  = state == DMA_FIN;
    go    = accept || (ok && !(state_n inside {DMA_FIN, DMA_ERR}));
    cmd   = (state_n inside {DMA_LD_WR, DMA_GO, DMA_ST_WR}) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
    wdata = state_n == DMA_GO ? ACCEL_GO : (ok ? rdata : hold);
    addr  = state_n == DMA_LD_RD ? (state == DMA_IDLE ? src_addr : word_addr(src, idx + 4'd1)) :
            state_n == DMA_LD_WR ? word_addr(ACCEL_BASE + ACCEL_DATA_OFS, idx) :
            state_n == DMA_ST_RD ? word_addr(ACCEL_BASE + ACCEL_STATE_OFS,
                                             state == DMA_POLL ? 4'd0 : {1'b0, didx + 3'd1}) :
            state_n == DMA_ST_WR ? word_addr(dst, {1'b0, didx}) :
            ACCEL_BASE + ACCEL_CSR_OFS;
  end
  scr1_dmem_master_if u_mif (
    .clk          (clk),
    .rst          (rst),
    .go           (go),
    .cmd          (cmd),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .ok           (ok),
    .err          (err),
    .dmem_req     (dmem_req),
    .dmem_cmd     (dmem_cmd),
    .dmem_width   (dmem_width),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_req_ack (dmem_req_ack),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp)
  );
endmodule

// File: tb/tb_scr1_accel_dma.sv
// tb_scr1_accel_dma: scoreboard bench with a reactive dmem slave and accelerator model
module tb_scr1_accel_dma;
  import scr1_accel_pkg::*;
  localparam logic [31:0] BASE = 32'h0001_0000;
  typedef struct packed {logic wr; logic [31:0] addr; logic [31:0] data;} txn_t;
  logic                 clk, rst, start, busy, done, error, dmem_req, dmem_req_ack;
  logic [31:0]          src_addr, dst_addr, dmem_addr, dmem_wdata, dmem_rdata;
  type_scr1_mem_cmd_e   dmem_cmd;
  type_scr1_mem_width_e dmem_width;
  type_scr1_mem_resp_e  dmem_resp;
  int vectors = 0, miscompares = 0, n;
  int req_n, rd_n, stall, polls, polls_needed, er_read, stall_mode;
  bit pend_s, pend_er, seen;
  logic [31:0] pend_data, cur_src, cur_dst, s_addr, s_wdata;
  type_scr1_mem_cmd_e s_cmd;
  txn_t exp_q[$];
  txn_t e;
  scr1_accel_dma #(.ACCEL_BASE(BASE), .POLL_MAX(16'd8)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .busy(busy), .done(done), .error(error), .dmem_req(dmem_req), .dmem_cmd(dmem_cmd),
    .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_req_ack(dmem_req_ack), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] src_word(input int i);
    return 32'h0302_0100 + 32'(i) * 32'h0404_0404;
  endfunction
  function automatic logic [31:0] digest(input int j);
    return 32'h6A09_E667 ^ (32'(j) * 32'h1357_9BDF);
  endfunction
  // Slave: acks on the cycle req is seen (unless stalling), responds the following cycle.
  always @(negedge clk) begin
    dmem_req_ack = 1'b0;
    dmem_resp    = SCR1_MEM_RESP_NOTRDY;
    if (rst) begin
      pend_s = 0;
      seen   = 0;
      stall  = 0;
    end else begin
      if (pend_s) begin
        pend_s     = 0;
        dmem_resp  = pend_er ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        dmem_rdata = pend_data;
      end
      if (dmem_req) begin
        if (!seen) begin
          seen = 1; req_n++;
          s_addr = dmem_addr; s_cmd = dmem_cmd; s_wdata = dmem_wdata;
          stall = (stall_mode != 0 && req_n % 3 == 0) ? 5 : 0;
        end else chk("stable", {dmem_cmd, dmem_addr, dmem_wdata}, {s_cmd, s_addr, s_wdata});
        if (stall > 0) stall--;
        else begin
          dmem_req_ack = 1'b1;
          seen = 0;
          pend_s = 1;
          pend_er = 0;
          pend_data = 32'hDEAD_BEEF;
          if (dmem_cmd == SCR1_MEM_CMD_RD) begin
            rd_n++;
            pend_er = rd_n == er_read;
            if (dmem_addr == BASE) begin
              polls++;
              pend_data = polls > polls_needed ? 32'h8000_0000 : 32'h0000_0000;
            end else if (dmem_addr >= BASE + 32'h4 && dmem_addr <= BASE + 32'h20)
              pend_data = digest(int'((dmem_addr - BASE - 32'h4) >> 2));
            else pend_data = src_word(int'((dmem_addr - cur_src) >> 2));
          end
          chk("req_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cmd", dmem_cmd == SCR1_MEM_CMD_WR, e.wr);
            chk("addr", dmem_addr, e.addr);
            if (e.wr) chk("wdata", dmem_wdata, e.data);
          end
        end
      end
    end
  end
  task automatic build(input logic [31:0] s, input logic [31:0] d, input int np, input int lim);
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back('{1'b0, s + 32'(4 * i), 32'h0});
      exp_q.push_back('{1'b1, BASE + 32'h24 + 32'(4 * i), src_word(i)});
    end
    exp_q.push_back('{1'b1, BASE, 32'h1});
    for (int p = 0; p < np; p++) exp_q.push_back('{1'b0, BASE, 32'h0});
    for (int j = 0; j < 8; j++) begin
      exp_q.push_back('{1'b0, BASE + 32'h4 + 32'(4 * j), 32'h0});
      exp_q.push_back('{1'b1, d + 32'(4 * j), digest(j)});
    end
    while (exp_q.size() > lim) void'(exp_q.pop_back());
  endtask
  task automatic kick(input logic [31:0] s, input logic [31:0] d);
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic setup(input logic [31:0] s, input logic [31:0] d, input int pn, input int er, input int stl);
    cur_src = s; cur_dst = d; polls = 0; polls_needed = pn;
    rd_n = 0; req_n = 0; er_read = er; stall_mode = stl;
  endtask
  task automatic run(input logic [31:0] s, input logic [31:0] d, input int pn, input int np,
                     input int lim, input int er, input int stl, input bit glitch,
                     input bit exp_err, input int lat);
    setup(s, d, pn, er, stl);
    build(s, d, np, lim);
    kick(s, d);
    chk("busy_after_start", busy, 1);
    n = 0;
    while (!done && !error && n < 3000) begin
      @(posedge clk);
      n++;
      #1;
      start = glitch && n == 10;
      if (glitch && n == 10) src_addr = 32'h0000_4000;
    end
    start = 1'b0;
    chk("finished", n < 3000, 1);
    chk("latency", n, lat);
    chk("error", error, exp_err);
    chk("done", done, !exp_err);
    chk("busy_end", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("done_low", done, 0);
    chk("error_sticky", error, exp_err);
    chk("sb_empty", exp_q.size(), 0);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_cmd", dmem_cmd, SCR1_MEM_CMD_RD);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_flags", {busy, done, error}, 0);
    chk("width", dmem_width, SCR1_MEM_WIDTH_WORD);
    #1 rst = 1'b0;
    run(32'h0000_1000, 32'h0000_2000, 3, 4, 999, 0, 0, 0, 0, 106);
    run(32'h0000_1100, 32'h0000_2100, 3, 4, 999, 0, 1, 0, 0, 191);
    run(32'h0000_1000, 32'h0000_2000, 3, 4, 13, 7, 0, 0, 1, 26);
    run(32'h0000_1200, 32'h0000_2200, 1000000, 8, 41, 0, 0, 0, 1, 82);
    chk("poll_reads", polls, 8);
    run(32'hFFFF_FFE0, 32'h0000_2000, 3, 4, 999, 0, 0, 1, 0, 106);
    setup(32'h0000_2000, 32'h0000_3000, 0, 0, 0);
    build(32'h0000_2000, 32'h0000_3000, 1, 999);
    kick(32'h0000_2000, 32'h0000_3000);
    n = 0;
    while (!(dmem_req && dmem_cmd == SCR1_MEM_CMD_WR && dmem_addr == 32'h0000_300C) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reach_st_wr3", n < 500, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", dmem_req, 0);
    chk("mid_rst_cmd", dmem_cmd, SCR1_MEM_CMD_RD);
    chk("mid_rst_addr", dmem_addr, 0);
    chk("mid_rst_wdata", dmem_wdata, 0);
    chk("mid_rst_flags", {busy, done, error}, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    run(32'h0000_2000, 32'h0000_3000, 3, 4, 999, 0, 0, 0, 0, 106);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
